// File: rtl/lianxi06_pkg.sv
// Shared definitions for the lianxi06 encoder/decoder pair: code word
// layout, one-hot helper and the decoded FIFO entry format.
package lianxi06_pkg;

  localparam int unsigned CODE_W  = 13;
  localparam int unsigned MODE_HI = 12;
  localparam int unsigned MODE_LO = 11;
  localparam int unsigned VAL_HI  = 10;
  localparam int unsigned VAL_LO  = 8;
  localparam int unsigned OH_HI   = 7;
  localparam int unsigned OH_LO   = 0;

  typedef struct packed {
    logic       err;
    logic [1:0] sel;
    logic [2:0] num;
  } entry_t;

  // One-hot encoding of a 3-bit value.
  function automatic logic [7:0] onehot3(input logic [2:0] value);
    return 8'b1 << value;
  endfunction

endpackage

// File: rtl/lianxi06_fifo.sv
// Synchronous DEPTH x WIDTH FIFO. Read data is forced to zero while empty so
// the head outputs are well defined without a separate mux downstream.
module lianxi06_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from the registered count only, so ready/valid never
  // depend combinationally on the opposite handshake.
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // Storage write; contents need no reset because reads are gated by count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lianxi06_dec.sv
// Receive-side decoder for lianxi06 code words: checks the one-hot field
// against the value field, buffers {err, sel, num} in a FIFO and keeps
// accepted-word and error counters.
module lianxi06_dec
  import lianxi06_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_num,
  output logic [1:0]        out_sel,
  output logic              out_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [15:0]       word_cnt,
  input  logic              clr_cnt
);

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_pop;
  logic             w_err;
  entry_t           w_in_entry;
  entry_t           w_head;
  logic [ERR_W-1:0] r_err_cnt;
  logic [15:0]      r_word_cnt;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Fields are passed through even when the one-hot check fails.
  assign w_err          = (in_code[OH_HI:OH_LO] != onehot3(in_code[VAL_HI:VAL_LO]));
  assign w_in_entry.err = w_err;
  assign w_in_entry.sel = in_code[MODE_HI:MODE_LO];
  assign w_in_entry.num = in_code[VAL_HI:VAL_LO];

  lianxi06_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_wdata (w_in_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_num = w_head.num;
  assign out_sel = w_head.sel;
  assign out_err = w_head.err;

  // Counters: clear wins over a same-cycle accept; err_cnt saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (clr_cnt) begin
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (w_accept) begin
      r_word_cnt <= r_word_cnt + 16'd1;
      if (w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign err_cnt  = r_err_cnt;
  assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_lianxi06_dec.sv
// Self-checking bench for lianxi06_dec: table-driven vectors plus directed
// sequences, with a scoreboard queue compared against the FIFO head on pop.
module tb_lianxi06_dec;
  import lianxi06_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned ERR_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_num;
  logic [1:0]        out_sel;
  logic              out_err;
  logic [ERR_W-1:0]  err_cnt;
  logic [15:0]       word_cnt;
  logic              clr_cnt;

  lianxi06_dec #(
    .DEPTH (DEPTH),
    .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt),
    .clr_cnt   (clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid) begin
      assert (!$isunknown(in_code)) else $error("in_code has X while in_valid");
    end
  end

  typedef struct {
    logic [12:0] code;
    logic [2:0]  num;
    logic [1:0]  sel;
    logic        err;
  } vec_t;

  vec_t   vecs[5];
  entry_t q[$];
  int     total;
  int     bad;

  // Reference decode: exactly one bit set, and it sits at the value position.
  function automatic entry_t model(input logic [12:0] c);
    entry_t      e;
    int          ones;
    logic [7:0]  oh;
    logic [2:0]  v;
    ones = 0;
    oh   = c[7:0];
    v    = c[10:8];
    for (int i = 0; i < 8; i++) if (oh[i]) ones++;
    e.err = !((ones == 1) && oh[v]);
    e.sel = c[12:11];
    e.num = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare the head with the scoreboard whenever a pop is about to happen.
  task automatic monitor();
    entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got %0h expected none", {out_err, out_sel, out_num});
          end else begin
            e = q.pop_front();
            chk("out_num", 32'(out_num), 32'(e.num));
            chk("out_sel", 32'(out_sel), 32'(e.sel));
            chk("out_err", 32'(out_err), 32'(e.err));
          end
        end else if (!out_valid) begin
          chk("idle_zero", 32'({out_err, out_sel, out_num}), 32'd0);
        end
      end
    end
  endtask

  // Drive one word and wait (bounded) for it to be accepted; in_valid is left high.
  task automatic send(input logic [12:0] c, input entry_t exp);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_code  = c;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (ok) begin
      q.push_back(exp);
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for code %0h", c);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  function automatic logic [12:0] good_word(input logic [1:0] s, input logic [2:0] v);
    logic [7:0] oh;
    oh = 8'b1 << v;
    return {s, v, oh};
  endfunction

  initial begin
    entry_t ex;
    logic [12:0] c;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;

    vecs[0] = '{13'b00_000_00000001, 3'd0, 2'd0, 1'b0};
    vecs[1] = '{13'b01_101_00100000, 3'd5, 2'd1, 1'b0};
    vecs[2] = '{13'b10_100_00010000, 3'd4, 2'd2, 1'b0};
    vecs[3] = '{13'b11_101_00100000, 3'd5, 2'd3, 1'b0};
    vecs[4] = '{13'b00_110_00000001, 3'd6, 2'd0, 1'b1};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({out_err, out_sel, out_num}), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    @(posedge clk);
    #1;

    // Valid words streaming with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex.num = vecs[i].num;
      ex.sel = vecs[i].sel;
      ex.err = vecs[i].err;
      send(vecs[i].code, ex);
    end
    in_valid = 1'b0;
    drain();
    chk("word_cnt_4", 32'(word_cnt), 32'd4);
    chk("err_cnt_0", 32'(err_cnt), 32'd0);

    // Corrupt word into an empty FIFO: visible one cycle after accept.
    ex.num = vecs[4].num;
    ex.sel = vecs[4].sel;
    ex.err = vecs[4].err;
    send(vecs[4].code, ex);
    in_valid = 1'b0;
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("err_cnt_1", 32'(err_cnt), 32'd1);
    chk("word_cnt_5", 32'(word_cnt), 32'd5);
    drain();

    // Backpressure: fill, hold the extra word, then release.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      c = good_word(2'(i), 3'(i + 1));
      send(c, model(c));
    end
    c        = good_word(2'd3, 3'd7);
    in_valid = 1'b1;
    in_code  = c;
    @(negedge clk);
    chk("full_not_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("full_held", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("no_comb_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ready_return", 32'(in_ready), 32'd1);
    q.push_back(model(c));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    chk("word_cnt_bp", 32'(word_cnt), 32'(5 + DEPTH + 1));

    // Clear racing an accepted corrupt word.
    in_valid = 1'b1;
    in_code  = 13'b00_110_00000001;
    clr_cnt  = 1'b1;
    @(negedge clk);
    chk("clr_ready", 32'(in_ready), 32'd1);
    ex.num = 3'd6;
    ex.sel = 2'd0;
    ex.err = 1'b1;
    q.push_back(ex);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_word_cnt", 32'(word_cnt), 32'd0);
    chk("clr_entry_valid", 32'(out_valid), 32'd1);
    drain();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      c = {2'($urandom_range(0, 3)), 3'b110, 8'b0000_0001};
      send(c, model(c));
    end
    in_valid = 1'b0;
    drain();
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    chk("word_cnt_300", 32'(word_cnt), 32'd300);

    // Word counter wrap after 65536 accepts.
    for (int i = 300; i < 65535; i++) begin
      c = good_word(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      send(c, model(c));
    end
    in_valid = 1'b0;
    chk("word_cnt_max", 32'(word_cnt), 32'h0000_FFFF);
    c = good_word(2'd2, 3'd3);
    send(c, model(c));
    in_valid = 1'b0;
    chk("word_cnt_wrap", 32'(word_cnt), 32'd0);
    chk("err_cnt_hold", 32'(err_cnt), 32'd255);
    drain();

    // Asynchronous reset with entries buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      c = good_word(2'(i), 3'(i));
      send(c, model(c));
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_word_cnt", 32'(word_cnt), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
